id_stage: RTL and testbench

Registered MIPS instruction-decode stage that sits between the IF/ID pipeline register and the execute stage. It decodes the logic, shift and immediate subset, reads two register-file ports and resolves operands with EX/MEM forwarding. It detects load-use hazards and presents the result through a valid/ready ID/EX output register. It also keeps a saturating stall counter for performance monitoring.

---
 rtl/id_stage.sv | 276 +++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: registered MIPS decode stage for the logic/shift/immediate subset.
// Reads rs/rt combinationally, resolves operands, detects hazards and holds
// the decoded instruction in a valid/ready ID/EX register.
// Build option: define ID_FWD_EN to enable EX/MEM forwarding. With forwarding
// enabled, only a load in EX causes a stall. Without it, any pending EX/MEM
// write to a source register stalls, and the register file must write through.
module id_stage #(
    parameter int unsigned N_REG       = 32,
    parameter int unsigned N_INST_ADDR = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned N_ALU_OP    = 8,
    parameter int unsigned N_ALU_SEL   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [N_INST_ADDR-1:0] i_pc,
    input  logic [31:0]            i_inst,
    output logic [4:0]             o_reg_0_addr,
    output logic [4:0]             o_reg_1_addr,
    output logic                   o_reg_0_ren,
    output logic                   o_reg_1_ren,
    input  logic [N_REG-1:0]       i_reg_0_data,
    input  logic [N_REG-1:0]       i_reg_1_data,
    input  logic                   i_ex_wen,
    input  logic                   i_ex_is_load,
    input  logic [4:0]             i_ex_waddr,
    input  logic [N_REG-1:0]       i_ex_wdata,
    input  logic                   i_mem_wen,
    input  logic [4:0]             i_mem_waddr,
    input  logic [N_REG-1:0]       i_mem_wdata,
    input  logic                   i_flush,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [N_INST_ADDR-1:0] o_pc,
    output logic [N_ALU_OP-1:0]    o_alu_op,
    output logic [N_ALU_SEL-1:0]   o_alu_sel,
    output logic [N_REG-1:0]       o_op_reg_0,
    output logic [N_REG-1:0]       o_op_reg_1,
    output logic                   o_reg_wen,
    output logic [4:0]             o_reg_waddr,
    output logic [CNT_W-1:0]       o_stall_cnt
);

    localparam logic [N_ALU_OP-1:0]  EXE_NOP_OP    = 8'b0000_0000;
    localparam logic [N_ALU_OP-1:0]  EXE_AND_OP    = 8'b0010_0100;
    localparam logic [N_ALU_OP-1:0]  EXE_OR_OP     = 8'b0010_0101;
    localparam logic [N_ALU_OP-1:0]  EXE_XOR_OP    = 8'b0010_0110;
    localparam logic [N_ALU_OP-1:0]  EXE_NOR_OP    = 8'b0010_0111;
    localparam logic [N_ALU_OP-1:0]  EXE_SLL_OP    = 8'b0111_1100;
    localparam logic [N_ALU_OP-1:0]  EXE_SRL_OP    = 8'b0000_0010;
    localparam logic [N_ALU_OP-1:0]  EXE_SRA_OP    = 8'b0000_0011;
    localparam logic [N_ALU_SEL-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [N_ALU_SEL-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [N_ALU_SEL-1:0] EXE_RES_SHIFT = 3'b010;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;

    assign opcode = i_inst[31:26];
    assign rs     = i_inst[25:21];
    assign rt     = i_inst[20:16];
    assign rd     = i_inst[15:11];
    assign sa     = i_inst[10:6];
    assign funct  = i_inst[5:0];
    assign imm    = i_inst[15:0];

    logic [N_ALU_OP-1:0]  dec_op;
    logic [N_ALU_SEL-1:0] dec_sel;
    logic                 dec_ren0, dec_ren1, dec_wen;
    logic [4:0]           dec_waddr;
    logic [N_REG-1:0]     dec_imm0, dec_imm1;

    // Instruction decode; disabled read ports carry the immediate or shift amount.
    always_comb begin
        dec_op    = EXE_NOP_OP;
        dec_sel   = EXE_RES_NOP;
        dec_ren0  = 1'b0;
        dec_ren1  = 1'b0;
        dec_wen   = 1'b0;
        dec_waddr = 5'd0;
        dec_imm0  = '0;
        dec_imm1  = '0;
        case (opcode)
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_sel   = EXE_RES_LOGIC;
                dec_ren0  = 1'b1;
                dec_wen   = 1'b1;
                dec_waddr = rt;
                dec_imm1  = N_REG'(imm);
                if (opcode == OP_ANDI) begin
                    dec_op = EXE_AND_OP;
                end else if (opcode == OP_XORI) begin
                    dec_op = EXE_XOR_OP;
                end else begin
                    dec_op = EXE_OR_OP;
                end
            end
            OP_LUI: begin
                dec_sel   = EXE_RES_LOGIC;
                dec_op    = EXE_OR_OP;
                dec_wen   = 1'b1;
                dec_waddr = rt;
                dec_imm1  = N_REG'({imm, 16'h0000});
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_OR, FN_AND, FN_XOR, FN_NOR: begin
                        dec_sel   = EXE_RES_LOGIC;
                        dec_ren0  = 1'b1;
                        dec_ren1  = 1'b1;
                        dec_wen   = 1'b1;
                        dec_waddr = rd;
                        case (funct)
                            FN_AND:  dec_op = EXE_AND_OP;
                            FN_XOR:  dec_op = EXE_XOR_OP;
                            FN_NOR:  dec_op = EXE_NOR_OP;
                            default: dec_op = EXE_OR_OP;
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec_sel   = EXE_RES_SHIFT;
                        dec_ren1  = 1'b1;
                        dec_wen   = 1'b1;
                        dec_waddr = rd;
                        dec_imm0  = N_REG'(sa);
                        case (funct)
                            FN_SRL:  dec_op = EXE_SRL_OP;
                            FN_SRA:  dec_op = EXE_SRA_OP;
                            default: dec_op = EXE_SLL_OP;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Writes to $0 are architecturally discarded.
        if (dec_waddr == 5'd0) begin
            dec_wen = 1'b0;
        end
    end

    assign o_reg_0_addr = rs;
    assign o_reg_1_addr = rt;
    assign o_reg_0_ren  = dec_ren0;
    assign o_reg_1_ren  = dec_ren1;

    logic [N_REG-1:0] op0, op1;
    logic             hz0, hz1, hazard;

    // Operand resolution and hazard detection per read port.
    always_comb begin
        op0 = dec_ren0 ? i_reg_0_data : dec_imm0;
        op1 = dec_ren1 ? i_reg_1_data : dec_imm1;
`ifdef ID_FWD_EN
        if (dec_ren0 && i_mem_wen && i_mem_waddr == rs) op0 = i_mem_wdata;
        if (dec_ren0 && i_ex_wen && !i_ex_is_load && i_ex_waddr == rs) op0 = i_ex_wdata;
        if (dec_ren1 && i_mem_wen && i_mem_waddr == rt) op1 = i_mem_wdata;
        if (dec_ren1 && i_ex_wen && !i_ex_is_load && i_ex_waddr == rt) op1 = i_ex_wdata;
        hz0 = dec_ren0 && rs != 5'd0 && i_ex_wen && i_ex_is_load && i_ex_waddr == rs;
        hz1 = dec_ren1 && rt != 5'd0 && i_ex_wen && i_ex_is_load && i_ex_waddr == rt;
`else
        hz0 = dec_ren0 && rs != 5'd0 &&
              ((i_ex_wen && i_ex_waddr == rs) || (i_mem_wen && i_mem_waddr == rs));
        hz1 = dec_ren1 && rt != 5'd0 &&
              ((i_ex_wen && i_ex_waddr == rt) || (i_mem_wen && i_mem_waddr == rt));
`endif
        // $0 always reads as zero, overriding any forwarded value.
        if (dec_ren0 && rs == 5'd0) op0 = '0;
        if (dec_ren1 && rt == 5'd0) op1 = '0;
        hazard = i_in_valid && (hz0 || hz1);
    end

`ifndef ID_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{i_ex_is_load, i_ex_wdata, i_mem_wdata};
`endif

    logic                   valid_q, valid_d;
    logic [N_INST_ADDR-1:0] pc_q, pc_d;
    logic [N_ALU_OP-1:0]    alu_op_q, alu_op_d;
    logic [N_ALU_SEL-1:0]   alu_sel_q, alu_sel_d;
    logic [N_REG-1:0]       op0_q, op0_d, op1_q, op1_d;
    logic                   wen_q, wen_d;
    logic [4:0]             waddr_q, waddr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign o_in_ready = i_rst_n && !i_flush && !hazard && (!valid_q || i_out_ready);

    // Next state of the ID/EX register and the stall counter.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        alu_op_d  = alu_op_q;
        alu_sel_d = alu_sel_q;
        op0_d     = op0_q;
        op1_d     = op1_q;
        wen_d     = wen_q;
        waddr_d   = waddr_q;
        cnt_d     = cnt_q;
        if (!i_flush && i_in_valid && o_in_ready) begin
            valid_d   = 1'b1;
            pc_d      = i_pc;
            alu_op_d  = dec_op;
            alu_sel_d = dec_sel;
            op0_d     = op0;
            op1_d     = op1;
            wen_d     = dec_wen;
            waddr_d   = dec_waddr;
        end else if (i_flush || i_out_ready) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            alu_op_d  = EXE_NOP_OP;
            alu_sel_d = EXE_RES_NOP;
            op0_d     = '0;
            op1_d     = '0;
            wen_d     = 1'b0;
            waddr_d   = 5'd0;
        end
        if (i_in_valid && !o_in_ready && !i_flush && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            alu_op_q  <= EXE_NOP_OP;
            alu_sel_q <= EXE_RES_NOP;
            op0_q     <= '0;
            op1_q     <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= 5'd0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            alu_op_q  <= alu_op_d;
            alu_sel_q <= alu_sel_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_out_valid = valid_q;
    assign o_pc        = pc_q;
    assign o_alu_op    = alu_op_q;
    assign o_alu_sel   = alu_sel_q;
    assign o_op_reg_0  = op0_q;
    assign o_op_reg_1  = op1_q;
    assign o_reg_wen   = wen_q;
    assign o_reg_waddr = waddr_q;
    assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table-driven directed test of id_stage plus hand-written
// sequences for hazards, back-pressure, flush and reset.
module tb_id_stage;

    localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27, OP_SLL = 8'h7c, OP_SRL = 8'h02, OP_SRA = 8'h03;
    localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2;

    logic        i_clk, i_rst_n, i_in_valid, o_in_ready;
    logic [31:0] i_pc, i_inst;
    logic [4:0]  o_reg_0_addr, o_reg_1_addr;
    logic        o_reg_0_ren, o_reg_1_ren;
    logic [31:0] i_reg_0_data, i_reg_1_data;
    logic        i_ex_wen, i_ex_is_load;
    logic [4:0]  i_ex_waddr;
    logic [31:0] i_ex_wdata;
    logic        i_mem_wen;
    logic [4:0]  i_mem_waddr;
    logic [31:0] i_mem_wdata;
    logic        i_flush, o_out_valid, i_out_ready;
    logic [31:0] o_pc;
    logic [7:0]  o_alu_op;
    logic [2:0]  o_alu_sel;
    logic [31:0] o_op_reg_0, o_op_reg_1;
    logic        o_reg_wen;
    logic [4:0]  o_reg_waddr;
    logic [15:0] o_stall_cnt;

    logic [31:0] rf [32];
    assign i_reg_0_data = rf[o_reg_0_addr];
    assign i_reg_1_data = rf[o_reg_1_addr];

    id_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_pc(i_pc), .i_inst(i_inst), .o_reg_0_addr(o_reg_0_addr), .o_reg_1_addr(o_reg_1_addr),
        .o_reg_0_ren(o_reg_0_ren), .o_reg_1_ren(o_reg_1_ren), .i_reg_0_data(i_reg_0_data),
        .i_reg_1_data(i_reg_1_data), .i_ex_wen(i_ex_wen), .i_ex_is_load(i_ex_is_load),
        .i_ex_waddr(i_ex_waddr), .i_ex_wdata(i_ex_wdata), .i_mem_wen(i_mem_wen),
        .i_mem_waddr(i_mem_waddr), .i_mem_wdata(i_mem_wdata), .i_flush(i_flush),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_pc(o_pc),
        .o_alu_op(o_alu_op), .o_alu_sel(o_alu_sel), .o_op_reg_0(o_op_reg_0),
        .o_op_reg_1(o_op_reg_1), .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr),
        .o_stall_cnt(o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exw, exl;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        memw;
        logic [4:0]  mema;
        logic [31:0] memd;
        logic        ren0, ren1;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] op0, op1;
        logic        wen;
        logic [4:0]  waddr;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                                input logic ren0, input logic ren1, input logic [7:0] op,
                                input logic [2:0] sel, input logic [31:0] op0,
                                input logic [31:0] op1, input logic wen,
                                input logic [4:0] waddr);
        vec_t v;
        v.inst = inst; v.pc = pc; v.ren0 = ren0; v.ren1 = ren1; v.op = op; v.sel = sel;
        v.op0 = op0; v.op1 = op1; v.wen = wen; v.waddr = waddr;
        v.exw = 1'b0; v.exl = 1'b0; v.exa = 5'd0; v.exd = 32'h0;
        v.memw = 1'b0; v.mema = 5'd0; v.memd = 32'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic valid, input logic [31:0] pc,
                           input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] op0, input logic [31:0] op1,
                           input logic wen, input logic [4:0] waddr);
        chk({tag, ".valid"}, 32'(o_out_valid), 32'(valid));
        chk({tag, ".pc"}, o_pc, pc);
        chk({tag, ".op"}, 32'(o_alu_op), 32'(op));
        chk({tag, ".sel"}, 32'(o_alu_sel), 32'(sel));
        chk({tag, ".op0"}, o_op_reg_0, op0);
        chk({tag, ".op1"}, o_op_reg_1, op1);
        chk({tag, ".wen"}, 32'(o_reg_wen), 32'(wen));
        chk({tag, ".waddr"}, 32'(o_reg_waddr), 32'(waddr));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_in_valid = 1'b0; i_flush = 1'b0; i_out_ready = 1'b1;
        i_ex_wen = 1'b0; i_ex_is_load = 1'b0; i_ex_waddr = 5'd0; i_ex_wdata = 32'h0;
        i_mem_wen = 1'b0; i_mem_waddr = 5'd0; i_mem_wdata = 32'h0;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        rf[0] = 32'h0;
        rf[1] = 32'h0000_0F00;

        vecs.push_back(mk(itype(6'h0d, 5'd1, 5'd2, 16'h00F0), 32'h100, 1, 0, OP_OR, SEL_LOGIC,
                          32'h0F00, 32'h00F0, 1, 5'd2));
        vecs.push_back(mk(itype(6'h0c, 5'd2, 5'd3, 16'h1234), 32'h104, 1, 0, OP_AND, SEL_LOGIC,
                          32'h1000_0002, 32'h1234, 1, 5'd3));
        vecs.push_back(mk(itype(6'h0e, 5'd0, 5'd4, 16'hFFFF), 32'h108, 1, 0, OP_XOR, SEL_LOGIC,
                          32'h0, 32'hFFFF, 1, 5'd4));
        vecs.push_back(mk(itype(6'h0f, 5'd5, 5'd7, 16'hABCD), 32'h10c, 0, 0, OP_OR, SEL_LOGIC,
                          32'h0, 32'hABCD_0000, 1, 5'd7));
        vecs.push_back(mk(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 32'h110, 1, 1, OP_OR, SEL_LOGIC,
                          32'h0F00, 32'h1000_0002, 1, 5'd3));
        vecs.push_back(mk(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h27), 32'h114, 1, 1, OP_NOR, SEL_LOGIC,
                          32'h0F00, 32'h1000_0002, 1, 5'd8));
        vecs.push_back(mk(rtype(5'd2, 5'd1, 5'd9, 5'd0, 6'h24), 32'h118, 1, 1, OP_AND, SEL_LOGIC,
                          32'h1000_0002, 32'h0F00, 1, 5'd9));
        vecs.push_back(mk(rtype(5'd4, 5'd2, 5'd10, 5'd0, 6'h26), 32'h11c, 1, 1, OP_XOR,
                          SEL_LOGIC, 32'h1000_0004, 32'h1000_0002, 1, 5'd10));
        vecs.push_back(mk(rtype(5'd3, 5'd1, 5'd10, 5'd4, 6'h00), 32'h120, 0, 1, OP_SLL,
                          SEL_SHIFT, 32'd4, 32'h0F00, 1, 5'd10));
        vecs.push_back(mk(rtype(5'd0, 5'd2, 5'd11, 5'd31, 6'h02), 32'h124, 0, 1, OP_SRL,
                          SEL_SHIFT, 32'd31, 32'h1000_0002, 1, 5'd11));
        vecs.push_back(mk(rtype(5'd0, 5'd1, 5'd12, 5'd1, 6'h03), 32'h128, 0, 1, OP_SRA,
                          SEL_SHIFT, 32'd1, 32'h0F00, 1, 5'd12));
        vecs.push_back(mk(rtype(5'd0, 5'd1, 5'd0, 5'd3, 6'h00), 32'h12c, 0, 1, OP_SLL,
                          SEL_SHIFT, 32'd3, 32'h0F00, 0, 5'd0));
        vecs.push_back(mk(itype(6'h08, 5'd1, 5'd2, 16'h0005), 32'h130, 0, 0, OP_NOP, SEL_NOP,
                          32'h0, 32'h0, 0, 5'd0));
        vecs.push_back(mk(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h134, 0, 0, OP_NOP, SEL_NOP,
                          32'h0, 32'h0, 0, 5'd0));
        vecs.push_back(mk(itype(6'h0d, 5'd1, 5'd0, 16'h0005), 32'h138, 1, 0, OP_OR, SEL_LOGIC,
                          32'h0F00, 32'h5, 0, 5'd0));
`ifdef ID_FWD_EN
        // EX and MEM both write $1: EX wins.
        v = mk(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 32'h13c, 1, 1, OP_OR, SEL_LOGIC,
               32'h11, 32'h1000_0002, 1, 5'd3);
        v.exw = 1; v.exa = 5'd1; v.exd = 32'h11; v.memw = 1; v.mema = 5'd1; v.memd = 32'h22;
        vecs.push_back(v);
        v = mk(rtype(5'd2, 5'd1, 5'd6, 5'd0, 6'h26), 32'h140, 1, 1, OP_XOR, SEL_LOGIC,
               32'h33, 32'h0F00, 1, 5'd6);
        v.exw = 1; v.exa = 5'd9; v.exd = 32'h99; v.memw = 1; v.mema = 5'd2; v.memd = 32'h33;
        vecs.push_back(v);
        v = mk(itype(6'h0d, 5'd1, 5'd5, 16'h0007), 32'h144, 1, 0, OP_OR, SEL_LOGIC,
               32'h44, 32'h7, 1, 5'd5);
        v.exw = 1; v.exl = 1; v.exa = 5'd9; v.memw = 1; v.mema = 5'd1; v.memd = 32'h44;
        vecs.push_back(v);
`endif

        // Reset: ready low while in reset, outputs take NOP values.
        idle();
        i_rst_n = 1'b0; i_in_valid = 1'b1; i_pc = 32'h50;
        i_inst = itype(6'h0d, 5'd1, 5'd2, 16'h00F0);
        #1;
        chk("rst_ready0", 32'(o_in_ready), 32'h0);
        tick(); tick();
        chk("rst_ready", 32'(o_in_ready), 32'h0);
        chk_out("rst", 0, 32'h0, OP_NOP, SEL_NOP, 32'h0, 32'h0, 0, 5'd0);
        chk("rst_cnt", 32'(o_stall_cnt), 32'h0);
        i_rst_n = 1'b1; i_in_valid = 1'b0;
        tick();

        // Table, applied back to back for full throughput.
        foreach (vecs[k]) begin
            i_in_valid = 1'b1; i_inst = vecs[k].inst; i_pc = vecs[k].pc;
            i_ex_wen = vecs[k].exw; i_ex_is_load = vecs[k].exl;
            i_ex_waddr = vecs[k].exa; i_ex_wdata = vecs[k].exd;
            i_mem_wen = vecs[k].memw; i_mem_waddr = vecs[k].mema; i_mem_wdata = vecs[k].memd;
            #1;
            chk($sformatf("v%0d.ren0", k), 32'(o_reg_0_ren), 32'(vecs[k].ren0));
            chk($sformatf("v%0d.ren1", k), 32'(o_reg_1_ren), 32'(vecs[k].ren1));
            chk($sformatf("v%0d.addr0", k), 32'(o_reg_0_addr), 32'(vecs[k].inst[25:21]));
            chk($sformatf("v%0d.addr1", k), 32'(o_reg_1_addr), 32'(vecs[k].inst[20:16]));
            chk($sformatf("v%0d.ready", k), 32'(o_in_ready), 32'h1);
            tick();
            chk_out($sformatf("v%0d", k), 1, vecs[k].pc, vecs[k].op, vecs[k].sel,
                    vecs[k].op0, vecs[k].op1, vecs[k].wen, vecs[k].waddr);
        end
        idle();
        tick();
        chk_out("drain", 0, 32'h0, OP_NOP, SEL_NOP, 32'h0, 32'h0, 0, 5'd0);
        chk("drain_cnt", 32'(o_stall_cnt), 32'(exp_cnt));

        // Load into $0 never creates a hazard.
        i_in_valid = 1'b1; i_pc = 32'h200; i_inst = rtype(5'd4, 5'd0, 5'd5, 5'd0, 6'h24);
        i_ex_wen = 1'b1; i_ex_is_load = 1'b1; i_ex_waddr = 5'd0;
        #1;
        chk("lu0_ready", 32'(o_in_ready), 32'h1);
        // Load-use on $4: one stall cycle, accepted once EX clears.
        i_ex_waddr = 5'd4; i_ex_wdata = 32'hDEAD;
        #1;
        chk("lu_ready", 32'(o_in_ready), 32'h0);
        tick();
        exp_cnt++;
        chk("lu_valid", 32'(o_out_valid), 32'h0);
        chk("lu_cnt", 32'(o_stall_cnt), 32'(exp_cnt));
        i_ex_wen = 1'b0; i_ex_is_load = 1'b0;
        #1;
        chk("lu_ready2", 32'(o_in_ready), 32'h1);
        tick();
        chk_out("lu", 1, 32'h200, OP_AND, SEL_LOGIC, 32'h1000_0004, 32'h0, 1, 5'd5);
        chk("lu_cnt2", 32'(o_stall_cnt), 32'(exp_cnt));

        // Non-load EX write to a source register.
        i_pc = 32'h300; i_inst = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
        i_ex_wen = 1'b1; i_ex_waddr = 5'd1; i_ex_wdata = 32'h11;
        i_mem_wen = 1'b1; i_mem_waddr = 5'd1; i_mem_wdata = 32'h22;
        #1;
`ifdef ID_FWD_EN
        chk("exm_ready", 32'(o_in_ready), 32'h1);
        tick();
        chk_out("exm", 1, 32'h300, OP_OR, SEL_LOGIC, 32'h11, 32'h1000_0002, 1, 5'd3);
`else
        chk("exm_ready", 32'(o_in_ready), 32'h0);
        tick();
        exp_cnt++;
        chk("exm_valid", 32'(o_out_valid), 32'h0);
        i_ex_wen = 1'b0;
        #1;
        chk("mem_ready", 32'(o_in_ready), 32'h0);
        tick();
        exp_cnt++;
        i_mem_wen = 1'b0;
        #1;
        chk("exm_ready2", 32'(o_in_ready), 32'h1);
        tick();
        chk_out("exm", 1, 32'h300, OP_OR, SEL_LOGIC, 32'h0F00, 32'h1000_0002, 1, 5'd3);
`endif
        chk("exm_cnt", 32'(o_stall_cnt), 32'(exp_cnt));
        idle();

        // Back-pressure: output held for 3 cycles, each counted as a stall.
        i_in_valid = 1'b1; i_pc = 32'h400; i_inst = itype(6'h0d, 5'd1, 5'd2, 16'h00F0);
        tick();
        i_pc = 32'h404; i_inst = itype(6'h0f, 5'd5, 5'd7, 16'hABCD); i_out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk($sformatf("bp%0d_ready", n), 32'(o_in_ready), 32'h0);
            tick();
            exp_cnt++;
            chk_out($sformatf("bp%0d", n), 1, 32'h400, OP_OR, SEL_LOGIC, 32'h0F00, 32'h00F0,
                    1, 5'd2);
        end
        chk("bp_cnt", 32'(o_stall_cnt), 32'(exp_cnt));
        i_out_ready = 1'b1;
        #1;
        chk("bp_ready", 32'(o_in_ready), 32'h1);
        tick();
        chk_out("bp_next", 1, 32'h404, OP_OR, SEL_LOGIC, 32'h0, 32'hABCD_0000, 1, 5'd7);

        // Flush with valid input while output is held: flush wins, nothing counted.
        i_pc = 32'h500; i_inst = itype(6'h0e, 5'd1, 5'd4, 16'h0001);
        i_out_ready = 1'b0; i_flush = 1'b1;
        #1;
        chk("fl_ready", 32'(o_in_ready), 32'h0);
        tick();
        chk_out("fl", 0, 32'h0, OP_NOP, SEL_NOP, 32'h0, 32'h0, 0, 5'd0);
        chk("fl_cnt", 32'(o_stall_cnt), 32'(exp_cnt));
        idle();
        tick();
        chk("fl_drop", 32'(o_out_valid), 32'h0);

        // Reset during a stall discards the held instruction and the count.
        i_in_valid = 1'b1; i_pc = 32'h600; i_inst = itype(6'h0d, 5'd1, 5'd2, 16'h00F0);
        tick();
        i_pc = 32'h604; i_inst = itype(6'h0c, 5'd2, 5'd3, 16'h0001); i_out_ready = 1'b0;
        tick();
        exp_cnt++;
        chk("rm_cnt", 32'(o_stall_cnt), 32'(exp_cnt));
        i_rst_n = 1'b0;
        #1;
        chk("rm_ready", 32'(o_in_ready), 32'h0);
        tick();
        exp_cnt = 0;
        chk_out("rm", 0, 32'h0, OP_NOP, SEL_NOP, 32'h0, 32'h0, 0, 5'd0);
        chk("rm_cnt0", 32'(o_stall_cnt), 32'(exp_cnt));
        i_rst_n = 1'b1; i_in_valid = 1'b0;
        tick();
        chk("rm_gone", 32'(o_out_valid), 32'h0);
        chk("rm_cnt1", 32'(o_stall_cnt), 32'(exp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
